acl_sampler: RTL

ACL_SAMPLER -- requirements
Module: acl_sampler

---
 rtl/acl_sampler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/acl_sampler.sv
// rtl/acl_sampler.sv - ADXL362 SPI sampler: one-time configuration, then periodic XYZ reads
//
// Purpose: after reset, writes POWER_CTL=0x02 (measurement mode) once, then every
// SAMPLE_PERIOD clk cycles reads XDATA/YDATA/ZDATA and publishes the top five bits
// of each axis as one packed word.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   miso       in   sensor serial data out, sampled directly
//   sclk       out  SPI clock, mode 0, idles low
//   mosi       out  SPI data to the sensor
//   cs_n       out  active-low chip select
//   acl_data   out  {X[7:3], Y[7:3], Z[7:3]}, 5-bit two's complement fields
//   data_valid out  one-cycle pulse when acl_data updates

module acl_sampler #(
  parameter int CLK_DIV       = 50,
  parameter int SAMPLE_PERIOD = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic [14:0] acl_data,
  output logic        data_valid
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int TMR_W = $clog2(SAMPLE_PERIOD);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);

  // Outgoing frames are left-aligned in a 40-bit shifter; unused tail bits are 0,
  // which also keeps mosi low while read data is clocked in.
  localparam logic [39:0] CFG_FRAME  = {24'h0A2D02, 16'h0000};
  localparam logic [39:0] READ_FRAME = {8'h0B, 8'h08, 24'h000000};
  localparam logic [5:0]  CFG_BITS   = 6'd24;
  localparam logic [5:0]  READ_BITS  = 6'd40;
  localparam logic [5:0]  RX_FIRST   = 6'd16;

  typedef enum logic [2:0] {CFG, CFG_GAP, WAIT, READ, DONE} state_t;

  state_t             r_state;
  logic               r_active;
  logic [DIV_W-1:0]   r_div;
  logic               r_high;
  logic [5:0]         r_bit;
  logic [39:0]        r_tx;
  logic [23:0]        r_rx;
  logic [TMR_W-1:0]   r_timer;
  logic               r_sclk;
  logic               r_mosi;
  logic               r_cs_n;
  logic [14:0]        r_data;
  logic               r_valid;

  logic [5:0]         w_nbits;
  logic [5:0]         w_bit_next;
  logic               w_div_wrap;
  logic               w_start;
  logic [39:0]        w_frame;

  assign w_nbits    = (r_state == READ) ? READ_BITS : CFG_BITS;
  assign w_bit_next = r_bit + 6'd1;
  assign w_div_wrap = (r_div == DIV_LAST);
  assign w_frame    = (r_state == CFG) ? CFG_FRAME : READ_FRAME;

  // A transaction starts on the edge that pulls cs_n low, so the first low cycle
  // already carries bit 0 on mosi. READ starts are timed from the previous start.
  assign w_start = ((r_state == CFG) && !r_active) ||
                   ((r_state == CFG_GAP) && w_div_wrap) ||
                   ((r_state == WAIT) && (r_timer == TMR_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= CFG;
      r_active <= 1'b0;
      r_div    <= '0;
      r_high   <= 1'b0;
      r_bit    <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_timer  <= '0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_timer <= r_timer + 1'b1;
      if (w_start) begin
        r_active <= 1'b1;
        r_cs_n   <= 1'b0;
        r_sclk   <= 1'b0;
        r_div    <= '0;
        r_high   <= 1'b0;
        r_bit    <= '0;
        r_mosi   <= w_frame[39];
        r_tx     <= {w_frame[38:0], 1'b0};
        if (r_state != CFG) begin
          r_state <= READ;
          r_timer <= '0;
        end
      end else begin
        case (r_state)
          CFG, READ: begin
            if (r_active) begin
              r_div <= w_div_wrap ? '0 : r_div + 1'b1;
              if (w_div_wrap) begin
                if (r_bit == w_nbits) begin
                  // Tail of CLK_DIV low cycles after the last falling edge is over.
                  r_cs_n   <= 1'b1;
                  r_active <= 1'b0;
                  r_state  <= (r_state == CFG) ? CFG_GAP : DONE;
                end else if (!r_high) begin
                  r_high <= 1'b1;
                  r_sclk <= 1'b1;
                  // miso has been stable for the whole low phase; take it on the rising edge.
                  if ((r_state == READ) && (r_bit >= RX_FIRST)) begin
                    r_rx <= {r_rx[22:0], miso};
                  end
                end else begin
                  r_high <= 1'b0;
                  r_sclk <= 1'b0;
                  r_bit  <= w_bit_next;
                  r_mosi <= (w_bit_next < w_nbits) ? r_tx[39] : 1'b0;
                  r_tx   <= {r_tx[38:0], 1'b0};
                end
              end
            end
          end
          CFG_GAP: begin
            r_div <= r_div + 1'b1;
          end
          DONE: begin
            r_data  <= {r_rx[23:19], r_rx[15:11], r_rx[7:3]};
            r_valid <= 1'b1;
            r_state <= WAIT;
          end
          WAIT: begin
          end
          default: begin
            r_state <= CFG;
          end
        endcase
      end
    end
  end

  assign sclk       = r_sclk;
  assign mosi       = r_mosi;
  assign cs_n       = r_cs_n;
  assign acl_data   = r_data;
  assign data_valid = r_valid;

endmodule
